// File: rtl/channel_mrc_equalizer_if.sv
// rtl/channel_mrc_equalizer_if.sv - LTF estimate, data symbol and equalised output bundle
interface channel_mrc_equalizer_if #(
  parameter int LTF_SIZE = 64,
  parameter int IN_W     = 22,
  parameter int OUT_W    = 24,
  parameter int DATASYMS = 12
);
  localparam int IDX_W = $clog2(DATASYMS);

  logic                      frame_start_i;
  logic [LTF_SIZE*IN_W-1:0]  chest_re_i;
  logic [LTF_SIZE*IN_W-1:0]  chest_im_i;
  logic                      chest_valid_i;
  logic [LTF_SIZE*IN_W-1:0]  data_re_i;
  logic [LTF_SIZE*IN_W-1:0]  data_im_i;
  logic                      data_valid_i;
  logic [LTF_SIZE*OUT_W-1:0] eq_re_o;
  logic [LTF_SIZE*OUT_W-1:0] eq_im_o;
  logic                      eq_valid_o;
  logic [IDX_W-1:0]          sym_idx_o;
  logic                      frame_done_o;
  logic                      busy_o;

  modport master (
    output frame_start_i, chest_re_i, chest_im_i, chest_valid_i,
    output data_re_i, data_im_i, data_valid_i,
    input  eq_re_o, eq_im_o, eq_valid_o, sym_idx_o, frame_done_o, busy_o
  );

  modport slave (
    input  frame_start_i, chest_re_i, chest_im_i, chest_valid_i,
    input  data_re_i, data_im_i, data_valid_i,
    output eq_re_o, eq_im_o, eq_valid_o, sym_idx_o, frame_done_o, busy_o
  );
endinterface

// File: rtl/channel_mrc_equalizer.sv
// rtl/channel_mrc_equalizer.sv - two-LTF channel averaging and conj(H) equaliser, all lanes in parallel
// Optional clamping of out-of-range lanes: define MRC_EQ_SATURATE_EN (default build wraps).
module channel_mrc_equalizer #(
  parameter int LTF_SIZE  = 64,
  parameter int IN_W      = 22,
  parameter int DATASYMS  = 12,
  parameter int OUT_SHIFT = 20,
  parameter int OUT_W     = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  channel_mrc_equalizer_if.slave bus
);
  localparam int IDX_W = $clog2(DATASYMS);
  localparam int PW    = 2 * IN_W;
  localparam int SW    = 2 * IN_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATASYMS - 1);
`ifdef MRC_EQ_SATURATE_EN
  localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
`endif

  typedef enum logic [1:0] {IDLE, LTF1, LTF2, DATA} state_t;

  state_t           state;
  logic [IDX_W-1:0] sym_cnt;
  logic             cap1, cap2, accept;

  // A restart always wins over any capture or data accept in the same cycle.
  assign cap1   = (state == LTF1) && bus.chest_valid_i && !bus.frame_start_i;
  assign cap2   = (state == LTF2) && bus.chest_valid_i && !bus.frame_start_i;
  assign accept = (state == DATA) && bus.data_valid_i  && !bus.frame_start_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      sym_cnt    <= '0;
      bus.busy_o <= 1'b0;
    end else if (bus.frame_start_i) begin
      state      <= LTF1;
      bus.busy_o <= 1'b1;
    end else begin
      case (state)
        LTF1: if (bus.chest_valid_i) state <= LTF2;
        LTF2: if (bus.chest_valid_i) begin
          state   <= DATA;
          sym_cnt <= '0;
        end
        DATA: if (bus.data_valid_i) begin
          sym_cnt <= sym_cnt + 1'b1;
          if (sym_cnt == LAST_IDX) begin
            state      <= IDLE;
            bus.busy_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  logic signed [IN_W-1:0] h1_re [LTF_SIZE];
  logic signed [IN_W-1:0] h1_im [LTF_SIZE];
  logic signed [IN_W-1:0] h_re  [LTF_SIZE];
  logic signed [IN_W-1:0] h_im  [LTF_SIZE];
  logic signed [IN_W-1:0] h_nxt_re [LTF_SIZE];
  logic signed [IN_W-1:0] h_nxt_im [LTF_SIZE];
  logic signed [PW-1:0]   m_rr [LTF_SIZE];
  logic signed [PW-1:0]   m_ii [LTF_SIZE];
  logic signed [PW-1:0]   m_ir [LTF_SIZE];
  logic signed [PW-1:0]   m_ri [LTF_SIZE];
  logic signed [PW-1:0]   p_rr [LTF_SIZE];
  logic signed [PW-1:0]   p_ii [LTF_SIZE];
  logic signed [PW-1:0]   p_ir [LTF_SIZE];
  logic signed [PW-1:0]   p_ri [LTF_SIZE];
  logic [OUT_W-1:0]       red_re [LTF_SIZE];
  logic [OUT_W-1:0]       red_im [LTF_SIZE];

  for (genvar k = 0; k < LTF_SIZE; k++) begin : g_lane
    logic signed [IN_W-1:0] c_re, c_im, d_re, d_im;
    logic signed [IN_W:0]   avg_re, avg_im;
    logic signed [SW-1:0]   sum_re, sum_im, sh_re, sh_im;
    logic                   unused_lsb;

    assign c_re = bus.chest_re_i[k*IN_W +: IN_W];
    assign c_im = bus.chest_im_i[k*IN_W +: IN_W];
    assign d_re = bus.data_re_i[k*IN_W +: IN_W];
    assign d_im = bus.data_im_i[k*IN_W +: IN_W];

    // Dropping the LSB of the widened sum is an arithmetic shift, i.e. floor division by 2.
    assign avg_re      = (IN_W + 1)'(h1_re[k]) + (IN_W + 1)'(c_re);
    assign avg_im      = (IN_W + 1)'(h1_im[k]) + (IN_W + 1)'(c_im);
    assign h_nxt_re[k] = avg_re[IN_W:1];
    assign h_nxt_im[k] = avg_im[IN_W:1];
    assign unused_lsb  = avg_re[0] ^ avg_im[0];

    assign m_rr[k] = PW'(d_re) * PW'(h_re[k]);
    assign m_ii[k] = PW'(d_im) * PW'(h_im[k]);
    assign m_ir[k] = PW'(d_im) * PW'(h_re[k]);
    assign m_ri[k] = PW'(d_re) * PW'(h_im[k]);

    assign sum_re = SW'(p_rr[k]) + SW'(p_ii[k]);
    assign sum_im = SW'(p_ir[k]) - SW'(p_ri[k]);
    assign sh_re  = sum_re >>> OUT_SHIFT;
    assign sh_im  = sum_im >>> OUT_SHIFT;

`ifdef MRC_EQ_SATURATE_EN
    assign red_re[k] = (sh_re > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                       (sh_re < SAT_MIN) ? SAT_MIN[OUT_W-1:0] : sh_re[OUT_W-1:0];
    assign red_im[k] = (sh_im > SAT_MAX) ? SAT_MAX[OUT_W-1:0] :
                       (sh_im < SAT_MIN) ? SAT_MIN[OUT_W-1:0] : sh_im[OUT_W-1:0];
`else
    logic unused_hi;
    assign red_re[k] = sh_re[OUT_W-1:0];
    assign red_im[k] = sh_im[OUT_W-1:0];
    assign unused_hi = ^{sh_re[SW-1:OUT_W], sh_im[SW-1:OUT_W]};
`endif
  end

  logic             s1_valid;
  logic [IDX_W-1:0] s1_idx;
  logic             s1_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid         <= 1'b0;
      s1_idx           <= '0;
      s1_last          <= 1'b0;
      bus.eq_valid_o   <= 1'b0;
      bus.sym_idx_o    <= '0;
      bus.frame_done_o <= 1'b0;
      bus.eq_re_o      <= '0;
      bus.eq_im_o      <= '0;
      for (int k = 0; k < LTF_SIZE; k++) begin
        h1_re[k] <= '0;
        h1_im[k] <= '0;
        h_re[k]  <= '0;
        h_im[k]  <= '0;
        p_rr[k]  <= '0;
        p_ii[k]  <= '0;
        p_ir[k]  <= '0;
        p_ri[k]  <= '0;
      end
    end else begin
      s1_valid         <= accept;
      bus.eq_valid_o   <= s1_valid;
      bus.frame_done_o <= s1_valid && s1_last;
      if (accept) begin
        s1_idx  <= sym_cnt;
        s1_last <= (sym_cnt == LAST_IDX);
      end
      if (s1_valid) bus.sym_idx_o <= s1_idx;
      for (int k = 0; k < LTF_SIZE; k++) begin
        if (bus.frame_start_i) begin
          h1_re[k] <= '0;
          h1_im[k] <= '0;
        end else if (cap1) begin
          h1_re[k] <= bus.chest_re_i[k*IN_W +: IN_W];
          h1_im[k] <= bus.chest_im_i[k*IN_W +: IN_W];
        end
        if (cap2) begin
          h_re[k] <= h_nxt_re[k];
          h_im[k] <= h_nxt_im[k];
        end
        if (accept) begin
          p_rr[k] <= m_rr[k];
          p_ii[k] <= m_ii[k];
          p_ir[k] <= m_ir[k];
          p_ri[k] <= m_ri[k];
        end
        if (s1_valid) begin
          bus.eq_re_o[k*OUT_W +: OUT_W] <= red_re[k];
          bus.eq_im_o[k*OUT_W +: OUT_W] <= red_im[k];
        end
      end
    end
  end
endmodule

// File: tb/tb_channel_mrc_equalizer.sv
// tb/tb_channel_mrc_equalizer.sv - scoreboard bench for channel_mrc_equalizer (shift 20 and shift 0 instances)
module tb_channel_mrc_equalizer;
  localparam int L = 64, IW = 22, OW = 24, NSYM = 12;
  typedef logic [L*IW-1:0] ivec_t;
  typedef logic [L*OW-1:0] ovec_t;
  typedef struct {
    ovec_t      re;
    ovec_t      im;
    logic [3:0] idx;
    logic       last;
    int         due;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     cyc = 0, checks = 0, failures = 0, sym = 0;
  exp_t   q20[$], q0[$];
  longint mh1_re[L], mh1_im[L], mh_re[L], mh_im[L];

  channel_mrc_equalizer_if ifc ();
  channel_mrc_equalizer_if ifc0 ();
  assign ifc0.frame_start_i = ifc.frame_start_i;
  assign ifc0.chest_re_i    = ifc.chest_re_i;
  assign ifc0.chest_im_i    = ifc.chest_im_i;
  assign ifc0.chest_valid_i = ifc.chest_valid_i;
  assign ifc0.data_re_i     = ifc.data_re_i;
  assign ifc0.data_im_i     = ifc.data_im_i;
  assign ifc0.data_valid_i  = ifc.data_valid_i;

  channel_mrc_equalizer dut (.clk_i(clk), .rst_i(rst), .bus(ifc));
  channel_mrc_equalizer #(.OUT_SHIFT(0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(ifc0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint sx(input logic [IW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [OW-1:0] red(input longint s, input int sh);
    longint t;
    t = s >>> sh;
`ifdef MRC_EQ_SATURATE_EN
    if (t > 64'sd8388607) t = 64'sd8388607;
    else if (t < -64'sd8388608) t = -64'sd8388608;
`endif
    return OW'(t);
  endfunction

  function automatic ivec_t fill(input int v);
    ivec_t r;
    for (int k = 0; k < L; k++) r[k*IW +: IW] = IW'(v);
    return r;
  endfunction

  function automatic ivec_t rnd(input int mag);
    ivec_t r;
    for (int k = 0; k < L; k++) r[k*IW +: IW] = IW'(int'($urandom_range(2 * mag, 0)) - mag);
    return r;
  endfunction

  function automatic int first_bad(input ovec_t a, b, c, d);
    for (int k = 0; k < L; k++)
      if (a[k*OW +: OW] !== b[k*OW +: OW] || c[k*OW +: OW] !== d[k*OW +: OW]) return k;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic score(input string tag, input ovec_t re, im, input logic [3:0] idx,
                       input logic done, input bit have, input exp_t e);
    int lane;
    checks++;
    assert (have) else begin
      failures++;
      $error("FAIL %s_unexpected got=eq_valid exp=no_output", tag);
    end
    if (have) begin
      checks++;
      assert ({re, im, idx, done} === {e.re, e.im, e.idx, e.last}) else begin
        failures++;
        lane = first_bad(re, e.re, im, e.im);
        $error("FAIL %s_data idx got=%0d exp=%0d done got=%0b exp=%0b lane%0d re got=%0h exp=%0h im got=%0h exp=%0h",
               tag, idx, e.idx, done, e.last, lane, re[lane*OW +: OW], e.re[lane*OW +: OW],
               im[lane*OW +: OW], e.im[lane*OW +: OW]);
      end
      checks++;
      assert (cyc === e.due) else begin
        failures++;
        $error("FAIL %s_latency got=%0d exp=%0d", tag, cyc, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (!rst && ifc.eq_valid_o) begin
      have = (q20.size() > 0);
      if (have) e = q20.pop_front();
      score("eq20", ifc.eq_re_o, ifc.eq_im_o, ifc.sym_idx_o, ifc.frame_done_o, have, e);
    end
    if (!rst && ifc0.eq_valid_o) begin
      have = (q0.size() > 0);
      if (have) e = q0.pop_front();
      score("eq0", ifc0.eq_re_o, ifc0.eq_im_o, ifc0.sym_idx_o, ifc0.frame_done_o, have, e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fs(input bit with_chest);
    ifc.frame_start_i = 1'b1;
    ifc.chest_valid_i = with_chest;
    ifc.chest_re_i    = fill(12345);
    ifc.chest_im_i    = fill(-777);
    step();
    ifc.frame_start_i = 1'b0;
    ifc.chest_valid_i = 1'b0;
  endtask

  // role 1: first LTF, role 2: second LTF (averaged), role 0: expected to be ignored
  task automatic do_ltf(input ivec_t re, im, input int role);
    ifc.chest_re_i    = re;
    ifc.chest_im_i    = im;
    ifc.chest_valid_i = 1'b1;
    step();
    ifc.chest_valid_i = 1'b0;
    for (int k = 0; k < L; k++) begin
      if (role == 1) begin
        mh1_re[k] = sx(re[k*IW +: IW]);
        mh1_im[k] = sx(im[k*IW +: IW]);
      end else if (role == 2) begin
        mh_re[k] = (mh1_re[k] + sx(re[k*IW +: IW])) >>> 1;
        mh_im[k] = (mh1_im[k] + sx(im[k*IW +: IW])) >>> 1;
      end
    end
    if (role == 2) sym = 0;
  endtask

  task automatic do_data(input ivec_t re, im, input bit acc, input bit fs);
    exp_t   e20, e0;
    longint dr, di, pr, pi;
    ifc.data_re_i     = re;
    ifc.data_im_i     = im;
    ifc.data_valid_i  = 1'b1;
    ifc.frame_start_i = fs;
    if (acc) begin
      for (int k = 0; k < L; k++) begin
        dr = sx(re[k*IW +: IW]);
        di = sx(im[k*IW +: IW]);
        pr = dr * mh_re[k] + di * mh_im[k];
        pi = di * mh_re[k] - dr * mh_im[k];
        e20.re[k*OW +: OW] = red(pr, 20);
        e20.im[k*OW +: OW] = red(pi, 20);
        e0.re[k*OW +: OW]  = red(pr, 0);
        e0.im[k*OW +: OW]  = red(pi, 0);
      end
      e20.idx  = 4'(sym);
      e20.last = (sym == NSYM - 1);
      e20.due  = cyc + 2;
      e0.idx   = e20.idx;
      e0.last  = e20.last;
      e0.due   = e20.due;
      q20.push_back(e20);
      q0.push_back(e0);
      sym++;
    end
    step();
    ifc.data_valid_i  = 1'b0;
    ifc.frame_start_i = 1'b0;
  endtask

  initial begin
    ifc.frame_start_i = 1'b0;
    ifc.chest_valid_i = 1'b0;
    ifc.data_valid_i  = 1'b0;
    ifc.chest_re_i    = '0;
    ifc.chest_im_i    = '0;
    ifc.data_re_i     = '0;
    ifc.data_im_i     = '0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_eq_valid", ifc.eq_valid_o, 0);
    chk("rst_busy", ifc.busy_o, 0);
    chk("rst_sym_idx", ifc.sym_idx_o, 0);
    chk("rst_frame_done", ifc.frame_done_o, 0);
    chk("rst_eq_re_lane0", ifc.eq_re_o[23:0], 0);

    // H = (200,0); data 1<<14 -> 3
    do_fs(1'b0);
    chk("busy_after_fs", ifc.busy_o, 1);
    do_ltf(fill(100), fill(0), 1);
    do_ltf(fill(300), fill(0), 2);
    do_data(fill(1 << 14), fill(0), 1'b1, 1'b0);
    step();
    chk("basic_valid", ifc.eq_valid_o, 1);
    chk("basic_re_lane0", ifc.eq_re_o[23:0], 24'd3);
    chk("basic_re_lane63", ifc.eq_re_o[L*OW-1 -: OW], 24'd3);
    chk("basic_im_lane0", ifc.eq_im_o[23:0], 24'd0);

    // restart with a simultaneous chest (not captured); floor averaging -> H = (-2,0)
    do_fs(1'b1);
    do_ltf(fill(-3), fill(0), 1);
    do_ltf(fill(0), fill(0), 2);
    do_data(fill(1 << 20), fill(0), 1'b1, 1'b0);
    step();
    chk("floor_re_lane0", ifc.eq_re_o[23:0], 24'hFFFFFE);

    // full frame of 12 random symbols
    do_fs(1'b0);
    do_data(rnd(1000), rnd(1000), 1'b0, 1'b0);
    do_ltf(rnd(1 << 20), rnd(1 << 20), 1);
    do_ltf(rnd(1 << 20), rnd(1 << 20), 2);
    do_ltf(rnd(1 << 20), rnd(1 << 20), 0);
    for (int i = 0; i < NSYM - 1; i++) do_data(rnd(1 << 20), rnd(1 << 20), 1'b1, 1'b0);
    chk("busy_before_last", ifc.busy_o, 1);
    do_data(rnd(1 << 20), rnd(1 << 20), 1'b1, 1'b0);
    chk("busy_after_last", ifc.busy_o, 0);
    do_data(rnd(1 << 20), rnd(1 << 20), 1'b0, 1'b0);
    repeat (3) step();

    // restart after symbol 5, coinciding with a data strobe
    do_fs(1'b0);
    do_ltf(rnd(1 << 19), rnd(1 << 19), 1);
    do_ltf(rnd(1 << 19), rnd(1 << 19), 2);
    for (int i = 0; i < 6; i++) do_data(rnd(1 << 20), rnd(1 << 20), 1'b1, 1'b0);
    do_data(rnd(1 << 20), rnd(1 << 20), 1'b0, 1'b1);
    do_data(rnd(1 << 20), rnd(1 << 20), 1'b0, 1'b0);
    do_ltf(rnd(1 << 19), rnd(1 << 19), 1);
    do_data(rnd(1 << 20), rnd(1 << 20), 1'b0, 1'b0);
    do_ltf(rnd(1 << 19), rnd(1 << 19), 2);
    do_data(rnd(1 << 20), rnd(1 << 20), 1'b1, 1'b0);
    do_data(rnd(1 << 20), rnd(1 << 20), 1'b1, 1'b0);
    repeat (3) step();

    // overflow on the unshifted instance
    do_fs(1'b0);
    do_ltf(fill(2097151), fill(0), 1);
    do_ltf(fill(2097151), fill(0), 2);
    do_data(fill(2097151), fill(0), 1'b1, 1'b0);
    step();
`ifdef MRC_EQ_SATURATE_EN
    chk("ovf_re_lane0", ifc0.eq_re_o[23:0], 24'h7FFFFF);
`else
    chk("ovf_re_lane0", ifc0.eq_re_o[23:0], 24'hC00001);
`endif
    chk("ovf_im_lane0", ifc0.eq_im_o[23:0], 24'd0);

    // reset while a symbol is in flight
    do_data(rnd(1 << 20), rnd(1 << 20), 1'b1, 1'b0);
    rst = 1'b1;
    step();
    q20.delete();
    q0.delete();
    sym = 0;
    chk("midrst_eq_valid", ifc.eq_valid_o, 0);
    chk("midrst_busy", ifc.busy_o, 0);
    rst = 1'b0;
    do_data(rnd(1000), rnd(1000), 1'b0, 1'b0);
    do_data(rnd(1000), rnd(1000), 1'b0, 1'b0);
    do_ltf(rnd(1000), rnd(1000), 0);
    do_fs(1'b0);
    do_ltf(rnd(1 << 20), rnd(1 << 20), 1);
    do_ltf(rnd(1 << 20), rnd(1 << 20), 2);
    do_data(rnd(1 << 20), rnd(1 << 20), 1'b1, 1'b0);
    do_data(rnd(1 << 20), rnd(1 << 20), 1'b1, 1'b0);
    repeat (4) step();

    chk("q20_drained", q20.size(), 0);
    chk("q0_drained", q0.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
